// File: rtl/usb_tx_serializer.sv
// USB full-speed TX serializer: SYNC prefix, LSB-first data shifting, bit stuffing
// after six consecutive ones, and EOP generation, paced by a per-bit clock divider.
module usb_tx_serializer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    input  logic       tx_last,
    output logic       tx_data_ready,
    output logic       bit_out,
    output logic [2:0] line_state,
    output logic       bit_strobe,
    output logic       tx_busy,
    output logic       tx_error
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_TOP = TW'(CLKS_PER_BIT - 1);

    // The state encoding doubles as the line_state code seen by the encoder.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_DATA  = 3'd2,
        S_STUFF = 3'd3,
        S_EOP1  = 3'd5,
        S_EOP2  = 3'd6,
        S_EOP_J = 3'd7
    } state_t;

    state_t        state;
    state_t        resume;
    logic [TW-1:0] timer;
    logic [7:0]    shreg;
    logic [2:0]    idx;
    logic [2:0]    ones;
    logic          last;

    state_t     adv_state;
    logic [7:0] adv_shreg;
    logic [2:0] adv_idx;
    logic       adv_last;
    logic       adv_bit;
    logic       set_err;
    logic [2:0] ones_n;
    logic       ready_due;

    assign line_state = state;

    // Handshake: tx_data_ready is a one-cycle pulse in the last clock of a byte's
    // final bit; the byte on tx_data is taken only if tx_data_valid is high in
    // that same cycle, otherwise the packet ends with an underrun.
    assign ready_due = (state == S_SYNC || state == S_DATA) && idx == 3'd7 && !last;

    always_comb begin
        adv_state = state;
        adv_shreg = shreg >> 1;
        adv_idx   = idx + 3'd1;
        adv_last  = last;
        adv_bit   = shreg[1];
        set_err   = 1'b0;
        ones_n    = bit_out ? ones + 3'd1 : 3'd0;
        if (idx == 3'd7) begin
            adv_idx = 3'd0;
            adv_bit = 1'b0;
            if (last) begin
                adv_state = S_EOP1;
            end else if (tx_data_valid) begin
                adv_state = S_DATA;
                adv_shreg = tx_data;
                adv_last  = tx_last;
                adv_bit   = tx_data[0];
            end else begin
                adv_state = S_EOP1;
                set_err   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= S_IDLE;
            resume        <= S_IDLE;
            timer         <= '0;
            shreg         <= '0;
            idx           <= '0;
            ones          <= '0;
            last          <= 1'b0;
            bit_out       <= 1'b1;
            bit_strobe    <= 1'b0;
            tx_data_ready <= 1'b0;
            tx_busy       <= 1'b0;
            tx_error      <= 1'b0;
        end else begin
            tx_data_ready <= 1'b0;
            bit_strobe    <= 1'b0;
            if (state == S_IDLE) begin
                if (tx_start) begin
                    state      <= S_SYNC;
                    timer      <= TIMER_TOP;
                    shreg      <= 8'h80;
                    idx        <= '0;
                    ones       <= '0;
                    last       <= 1'b0;
                    bit_out    <= 1'b0;
                    bit_strobe <= 1'b1;
                    tx_busy    <= 1'b1;
                    tx_error   <= 1'b0;
                end
            end else if (timer != '0) begin
                timer <= timer - TW'(1);
                if (timer == TW'(1) && ready_due) begin
                    tx_data_ready <= 1'b1;
                end
            end else begin
                timer      <= TIMER_TOP;
                bit_strobe <= 1'b1;
                case (state)
                    S_SYNC, S_DATA: begin
                        shreg <= adv_shreg;
                        idx   <= adv_idx;
                        last  <= adv_last;
                        if (set_err) begin
                            tx_error <= 1'b1;
                        end
                        // Shift/load happens now; STUFF only delays when the next bit goes out.
                        if (ones_n == 3'd6) begin
                            state   <= S_STUFF;
                            resume  <= adv_state;
                            bit_out <= 1'b0;
                            ones    <= '0;
                        end else begin
                            state   <= adv_state;
                            bit_out <= adv_bit;
                            ones    <= ones_n;
                        end
                    end
                    S_STUFF: begin
                        state   <= resume;
                        bit_out <= (resume == S_DATA) ? shreg[0] : 1'b0;
                    end
                    S_EOP1: begin
                        state   <= S_EOP2;
                        bit_out <= 1'b0;
                    end
                    S_EOP2: begin
                        state   <= S_EOP_J;
                        bit_out <= 1'b1;
                    end
                    default: begin
                        state      <= S_IDLE;
                        timer      <= '0;
                        bit_out    <= 1'b1;
                        bit_strobe <= 1'b0;
                        tx_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Bench for usb_tx_serializer: a bit-stream model (SYNC + data + stuffing + EOP)
// expanded to per-cycle expected outputs, plus hand-computed packet literals.
module tb_usb_tx_serializer;

    localparam int CPB = 4;

    logic       clk;
    logic       n_rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_last;
    logic       tx_data_ready;
    logic       bit_out;
    logic [2:0] line_state;
    logic       bit_strobe;
    logic       tx_busy;
    logic       tx_error;

    usb_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_last      (tx_last),
        .tx_data_ready(tx_data_ready),
        .bit_out      (bit_out),
        .line_state   (line_state),
        .bit_strobe   (bit_strobe),
        .tx_busy      (tx_busy),
        .tx_error     (tx_error)
    );

    // Expected word: {err, ready, busy, strobe, bit_out, line_state[2:0]}
    logic [7:0] exp_q[$];
    logic [7:0] pkt[0:3];
    logic       idle_err;
    logic       check_en;
    int         checks;
    int         fails;
    int         busy_cnt;
    int         rdy_cnt;
    int         period;
    int         stuff_at;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- compare process ----------------
    always @(posedge clk) begin
        logic [7:0] exp_w;
        logic [7:0] act_w;
        #1;
        if (check_en) begin
            exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : {idle_err, 7'b0001000};
            act_w = {tx_error, tx_data_ready, tx_busy, bit_strobe, bit_out, line_state};
            checks++;
            if (act_w !== exp_w) begin
                fails++;
                $display("FAIL cycle_out t=%0t got {err,rdy,busy,stb,bit,ls}=%b want %b", $time, act_w, exp_w);
            end
        end
    end

    // Packet statistics measured from the DUT, compared against literals.
    always @(posedge clk) begin
        #1;
        if (tx_busy) begin
            busy_cnt++;
            if (bit_strobe) begin
                if (line_state == 3'd3) stuff_at = period;
                period++;
            end
        end
        if (tx_data_ready) rdy_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    task automatic build_model(input int n, input int underrun_at);
        logic raw_bit[$];
        logic raw_rdy[$];
        logic [2:0] raw_ls[$];
        logic [4:0] per[$]; // {rdy, err, bit, ls}... packed as {rdy, err, bit} + ls below
        logic [2:0] per_ls[$];
        int nacc;
        int ones;
        logic err;
        for (int s = 0; s < 8; s++) begin
            raw_bit.push_back(s == 7);
            raw_rdy.push_back(s == 7);
            raw_ls.push_back(3'd1);
        end
        nacc = (underrun_at >= 0) ? underrun_at : n;
        for (int i = 0; i < nacc; i++) begin
            for (int b = 0; b < 8; b++) begin
                raw_bit.push_back(pkt[i][b]);
                raw_rdy.push_back(b == 7 && i != n - 1);
                raw_ls.push_back(3'd2);
            end
        end
        ones = 0;
        err = 1'b0;
        for (int j = 0; j < raw_bit.size(); j++) begin
            per.push_back({2'b00, raw_rdy[j], err, raw_bit[j]});
            per_ls.push_back(raw_ls[j]);
            if (underrun_at >= 0 && j == raw_bit.size() - 1) err = 1'b1;
            ones = raw_bit[j] ? ones + 1 : 0;
            if (ones == 6) begin
                per.push_back({3'b000, err, 1'b0});
                per_ls.push_back(3'd3);
                ones = 0;
            end
        end
        per.push_back({3'b000, err, 1'b0}); per_ls.push_back(3'd5);
        per.push_back({3'b000, err, 1'b0}); per_ls.push_back(3'd6);
        per.push_back({3'b000, err, 1'b1}); per_ls.push_back(3'd7);
        for (int p = 0; p < per.size(); p++) begin
            for (int c = 0; c < CPB; c++) begin
                exp_q.push_back({per[p][1], per[p][2] && (c == CPB - 1), 1'b1, c == 0, per[p][0], per_ls[p]});
            end
        end
        idle_err = err;
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_packet(input int n, input int underrun_at, input int exp_len);
        @(negedge clk);
        build_model(n, underrun_at);
        chk("model_len", exp_q.size(), exp_len);
        busy_cnt = 0;
        rdy_cnt  = 0;
        period   = 0;
        stuff_at = -1;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    task automatic feed_bytes(input int n, input int underrun_at, input bit poke);
        bit got;
        for (int i = 0; i < n; i++) begin
            tx_data       = pkt[i];
            tx_data_valid = (i != underrun_at);
            tx_last       = (i == n - 1);
            got = 1'b0;
            for (int k = 0; k < 300 && !got; k++) begin
                @(posedge clk);
                #1;
                tx_start = (poke && i == 1 && k == 5);
                if (tx_data_ready) got = 1'b1;
            end
            tx_start = 1'b0;
            if (!got) begin
                chk("ready_timeout", 0, 1);
                break;
            end
            @(posedge clk);
            #1;
            tx_data_valid = 1'b0;
            if (i == underrun_at) break;
        end
        tx_data_valid = 1'b0;
        tx_last       = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(posedge clk);
            #1;
            if (!tx_busy) done = 1'b1;
        end
        if (!done) chk("busy_timeout", 0, 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic run_packet(input int n, input int underrun_at, input bit poke, input int exp_len);
        start_packet(n, underrun_at, exp_len);
        feed_bytes(n, underrun_at, poke);
        wait_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        fails = 0;
        idle_err = 1'b0;
        check_en = 1'b0;
        busy_cnt = 0;
        rdy_cnt = 0;
        period = 0;
        stuff_at = -1;
        n_rst = 1'b0;
        tx_start = 1'b0;
        tx_data = 8'h00;
        tx_data_valid = 1'b0;
        tx_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bit_out", bit_out, 1);
        chk("rst_line_state", line_state, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_strobe", bit_strobe, 0);
        chk("rst_ready", tx_data_ready, 0);
        chk("rst_error", tx_error, 0);
        @(negedge clk);
        n_rst = 1'b1;
        check_en = 1'b1;
        repeat (2) @(posedge clk);

        // One byte 0x00: 19 bit periods, no stuffing.
        pkt[0] = 8'h00;
        run_packet(1, -1, 1'b0, 76);
        chk("p00_busy_cycles", busy_cnt, 76);
        chk("p00_ready_pulses", rdy_cnt, 1);
        chk("p00_stuff_at", stuff_at, -1);

        // 0xFF: SYNC's final one plus bits 0-4 force a stuff bit at period 13.
        pkt[0] = 8'hFF;
        run_packet(1, -1, 1'b0, 80);
        chk("pff_busy_cycles", busy_cnt, 80);
        chk("pff_stuff_at", stuff_at, 13);

        // 0xFC: six ones in bits 2-7, stuff lands right before EOP1.
        pkt[0] = 8'hFC;
        run_packet(1, -1, 1'b0, 80);
        chk("pfc_busy_cycles", busy_cnt, 80);
        chk("pfc_stuff_at", stuff_at, 16);

        // Underrun at the second ready pulse.
        pkt[0] = 8'h12;
        pkt[1] = 8'h34;
        run_packet(2, 1, 1'b0, 76);
        chk("urun_busy_cycles", busy_cnt, 76);
        chk("urun_ready_pulses", rdy_cnt, 2);
        chk("urun_error_sticky", tx_error, 1);

        // Two-byte packet with a stray tx_start mid-DATA; next start also clears tx_error.
        pkt[0] = 8'hA5;
        pkt[1] = 8'h3C;
        run_packet(2, -1, 1'b1, 108);
        chk("two_busy_cycles", busy_cnt, 108);
        chk("two_ready_pulses", rdy_cnt, 2);
        chk("two_error_cleared", tx_error, 0);

        // Asynchronous reset mid-DATA.
        pkt[0] = 8'h00;
        start_packet(1, -1, 76);
        tx_data = 8'h00;
        tx_data_valid = 1'b1;
        tx_last = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        check_en = 1'b0;
        n_rst = 1'b0;
        #1;
        chk("arst_bit_out", bit_out, 1);
        chk("arst_line_state", line_state, 0);
        chk("arst_busy", tx_busy, 0);
        chk("arst_strobe", bit_strobe, 0);
        chk("arst_ready", tx_data_ready, 0);
        exp_q.delete();
        idle_err = 1'b0;
        tx_data_valid = 1'b0;
        tx_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        check_en = 1'b1;
        repeat (2) @(posedge clk);
        run_packet(1, -1, 1'b0, 76);
        chk("post_rst_busy_cycles", busy_cnt, 76);
        chk("post_rst_ready_pulses", rdy_cnt, 1);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
